// File: rtl/ipv6_header_parser.sv
// IPv6 fixed-header parser: collects the 40-byte header from a DW-wide stream,
// presents it on a held handshake, then passes the payload through combinationally.
module ipv6_header_parser #(
  parameter int DW   = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DW-1:0]   s_data,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic            s_last,
  output logic [319:0]    hdr,
  output logic            hdr_valid,
  input  logic            hdr_ready,
  output logic            hdr_nopay,
  output logic [DW-1:0]   m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_last,
  output logic            err_version,
  output logic            err_trunc,
  output logic [CNTW-1:0] drop_cnt,
  output logic [1:0]      dbg_state
);

  // Handshake rule on every interface: a transfer happens on a rising edge
  // where valid and ready are both 1; valid never depends on ready.

  localparam int NB = 320 / DW;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_HOLD    = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DROP    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [319:0]    hdr_q, hdr_d;
  logic            nopay_q, nopay_d;
  logic            err_v_q, err_v_d;
  logic            err_t_q, err_t_d;
  logic [CNTW-1:0] drop_q, drop_d;
  logic            drop_inc;
  int              idx;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    hdr_d    = hdr_q;
    nopay_d  = nopay_q;
    err_v_d  = 1'b0;
    err_t_d  = 1'b0;
    drop_inc = 1'b0;
    s_ready  = 1'b0;
    m_valid  = 1'b0;
    m_last   = 1'b0;
    idx      = 319 - int'(beat_q) * DW;
    case (state_q)
      ST_HDR: begin
        s_ready = 1'b1;
        if (s_valid) begin
          hdr_d[idx -: DW] = s_data;
          if (beat_q == BW'(NB - 1)) begin
            beat_d = '0;
            // Version is checked on the updated image so NB==1 also works.
            if (hdr_d[319:316] == 4'd6) begin
              state_d = ST_HOLD;
              nopay_d = s_last;
            end else begin
              err_v_d  = 1'b1;
              drop_inc = 1'b1;
              state_d  = s_last ? ST_HDR : ST_DROP;
            end
          end else if (s_last) begin
            err_t_d  = 1'b1;
            drop_inc = 1'b1;
            beat_d   = '0;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      ST_HOLD: begin
        if (hdr_ready) state_d = nopay_q ? ST_HDR : ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        s_ready = m_ready;
        m_valid = s_valid;
        m_last  = s_last;
        if (s_valid && m_ready && s_last) state_d = ST_HDR;
      end
      ST_DROP: begin
        s_ready = 1'b1;
        if (s_valid && s_last) state_d = ST_HDR;
      end
      default: state_d = ST_HDR;
    endcase
    drop_d = (drop_inc && (drop_q != '1)) ? drop_q + CNTW'(1) : drop_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HDR;
      beat_q  <= '0;
      hdr_q   <= '0;
      nopay_q <= 1'b0;
      err_v_q <= 1'b0;
      err_t_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      hdr_q   <= hdr_d;
      nopay_q <= nopay_d;
      err_v_q <= err_v_d;
      err_t_q <= err_t_d;
      drop_q  <= drop_d;
    end
  end

  assign hdr         = hdr_q;
  assign hdr_valid   = (state_q == ST_HOLD);
  assign hdr_nopay   = nopay_q;
  assign m_data      = s_data;
  assign err_version = err_v_q;
  assign err_trunc   = err_t_q;
  assign drop_cnt    = drop_q;
  assign dbg_state   = state_q;

endmodule
